ex_epu: RTL and testbench
=========================

Name: ex_epu

Overview:
- Exception processing unit; sits directly upstream of the PSR/MSR file in EX/commit.
- Accepts one committing instruction per handshake and resolves faults, syscalls, RET and the external IRQ.
- Drives the PSR file's save, restore, EPC and ELSA controls.
- Runs a flush/redirect sequence toward the pipeline and frontend.

Parameters:
- CONFIG_DW, 64, datapath/PC width.
- IRQ_SYNC_STAGES, 2, flops in the IRQ synchroniser (legal range 2-3).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmt_valid  in  1  commit slot valid.
- cmt_ready  out  1  EPU can accept a commit.
- cmt_pc  in  CONFIG_DW  PC of the committing instruction.
- cmt_npc  in  CONFIG_DW  PC of the next sequential instruction.
- cmt_exc  in  5  {eret, edpf, esyscall, einsn, eipf}, bit 0 = eipf.
- cmt_lsa  in  CONFIG_DW  faulting load/store address.
- irq_async  in  1  level IRQ, asynchronous.
- msr_psr_ire  in  1  interrupt enable (PSR bypass value).
- msr_evect  in  CONFIG_DW  exception vector base.
- msr_epc  in  CONFIG_DW  current EPC (bypass value).
- msr_psr_save  out  1  save pulse.
- msr_psr_restore  out  1  restore pulse.
- msr_epc_nxt  out  CONFIG_DW  next EPC value.
- msr_epc_we  out  1  EPC write enable.
- msr_elsa_nxt  out  CONFIG_DW  next ELSA value.
- msr_elsa_we  out  1  ELSA write enable.
- flush_req  out  1  pipeline flush request.
- flush_ack  in  1  pipeline flush complete.
- redir_valid  out  1  frontend redirect valid.
- redir_ready  in  1  frontend accepts redirect.
- redir_pc  out  CONFIG_DW  redirect target.

Behaviour:
- States: IDLE, DRAIN, REDIR. cmt_ready = (state==IDLE).
- Reset: state IDLE. All pulse/valid outputs 0, all data outputs 0, cmt_ready=1.
- Reset mid-sequence: abandon the sequence, no pending pulse survives.
- Accept: cmt_valid & cmt_ready.
- Event on accept is selected by fixed priority: eipf > einsn > esyscall > edpf > eret > IRQ.
- IRQ is taken only when irq_sync=1, msr_psr_ire=1 and cmt_exc==0.
- Accepted commit with no event: no action, remain IDLE. Back-to-back commits accepted every cycle.
- Trap (any fault, syscall or IRQ) latency: the cycle after accept, exactly one cycle of pulses:
  - msr_psr_save=1, msr_epc_we=1.
  - msr_elsa_we=1 only for edpf.
  - Then enter DRAIN.
- EPC source:
  - cmt_pc for eipf/einsn/edpf (re-execute).
  - cmt_npc for esyscall and IRQ.
- ELSA = cmt_lsa.
- redir_pc = msr_evect sampled at accept + offset, modulo 2^CONFIG_DW.
- Vector offsets: eipf 0x18, einsn 0x08, esyscall 0x10, edpf 0x20, IRQ 0x28.
- RET latency: the cycle after accept, msr_psr_restore=1 for one cycle. redir_pc = msr_epc sampled at accept. Enter DRAIN.
- Lower-priority bits set alongside the winner are ignored; eret plus a fault → fault.
- DRAIN: flush_req=1 until flush_ack=1, then REDIR next cycle.
- flush_ack already high on DRAIN entry → exactly one DRAIN cycle.
- REDIR: redir_valid=1, redir_pc stable until redir_ready=1, then IDLE next cycle.
- redir_ready high on REDIR entry → one-cycle REDIR.
- IRQ path: irq_async goes through IRQ_SYNC_STAGES flops to give irq_sync. No latching; deasserted before a commit → not taken.
- IRQ coinciding with a RET accept: RET wins; IRQ is re-evaluated at the next accept.
- msr_* inputs are read only in the accept cycle.

Optional Feature:
- Macro: NCPU_EPU_PERF_CNT_EN.
- Defined:
  - Extra output epu_exc_cnt, 32 bits, reset 0.
  - Increments by 1 in each save-pulse cycle and wraps 0xFFFFFFFF→0.
  - RET does not count.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package/header holds:
  - EXC_W=5 and the cmt_exc bit indices.
  - Vector offset constants.
  - 2-bit state encodings (IDLE=0, DRAIN=1, REDIR=2).
- Sub-module ex_irq_sync: parameterised N-flop synchroniser with async active-low reset to 0.

Test Plan:
- einsn at cmt_pc=0x1000, evect=0x8000 → next cycle: save=1, epc_we=1, epc_nxt=0x1000, elsa_we=0. Then flush_req until ack; redir_pc=0x8008.
- edpf with lsa=0xDEAD0, pc=0x2000 → elsa_we=1, elsa_nxt=0xDEAD0, epc_nxt=0x2000, redir_pc=evect+0x20.
- cmt_exc=5'b10100 (eret+esyscall), npc=0x3004 → syscall taken, restore=0, epc_nxt=0x3004, redir_pc=evect+0x10.
- irq_async=1, ire=1, plain commit npc=0x4004 → IRQ taken no earlier than IRQ_SYNC_STAGES cycles later, epc_nxt=0x4004. Same with ire=0 → no action.
- RET with msr_epc=0x5000, redir_ready held 0 for 3 cycles → restore pulse once; redir_valid held 4 cycles with pc 0x5000; cmt_ready=0 throughout.
- Reset asserted in DRAIN → all outputs 0 immediately; after release cmt_ready=1, no pulse.

Source files
------------

// File: rtl/ex_epu_pkg.sv
// ex_epu shared definitions: exception bit indices, vector offsets,
// FSM state encoding and the resolved-event type.
package ex_epu_pkg;

  localparam int EXC_W = 5;

  localparam int EXC_EIPF     = 0;
  localparam int EXC_EINSN    = 1;
  localparam int EXC_ESYSCALL = 2;
  localparam int EXC_EDPF     = 3;
  localparam int EXC_ERET     = 4;

  localparam int VOFF_W = 8;

  localparam logic [VOFF_W-1:0] VOFF_EIPF     = 8'h18;
  localparam logic [VOFF_W-1:0] VOFF_EINSN    = 8'h08;
  localparam logic [VOFF_W-1:0] VOFF_ESYSCALL = 8'h10;
  localparam logic [VOFF_W-1:0] VOFF_EDPF     = 8'h20;
  localparam logic [VOFF_W-1:0] VOFF_IRQ      = 8'h28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REDIR = 2'd2
  } epu_state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_IPF,
    EV_INSN,
    EV_SYS,
    EV_DPF,
    EV_RET,
    EV_IRQ
  } epu_ev_t;

  function automatic logic [VOFF_W-1:0] vec_off(
    input epu_ev_t ev
  );
    logic [VOFF_W-1:0] off;
    case (ev)
      EV_IPF:  off = VOFF_EIPF;
      EV_INSN: off = VOFF_EINSN;
      EV_SYS:  off = VOFF_ESYSCALL;
      EV_DPF:  off = VOFF_EDPF;
      EV_IRQ:  off = VOFF_IRQ;
      default: off = '0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/ex_epu_if.sv
// ex_epu pipeline-side bundle: commit slot, flush handshake
// and frontend redirect handshake.
interface ex_epu_if
  import ex_epu_pkg::*;
#(
  parameter int DW = 64
) ();

  logic             cmt_valid;
  logic             cmt_ready;
  logic [DW-1:0]    cmt_pc;
  logic [DW-1:0]    cmt_npc;
  logic [EXC_W-1:0] cmt_exc;
  logic [DW-1:0]    cmt_lsa;

  logic             flush_req;
  logic             flush_ack;

  logic             redir_valid;
  logic             redir_ready;
  logic [DW-1:0]    redir_pc;

  modport master (
    output cmt_valid,
    output cmt_pc,
    output cmt_npc,
    output cmt_exc,
    output cmt_lsa,
    output flush_ack,
    output redir_ready,
    input  cmt_ready,
    input  flush_req,
    input  redir_valid,
    input  redir_pc
  );

  modport slave (
    input  cmt_valid,
    input  cmt_pc,
    input  cmt_npc,
    input  cmt_exc,
    input  cmt_lsa,
    input  flush_ack,
    input  redir_ready,
    output cmt_ready,
    output flush_req,
    output redir_valid,
    output redir_pc
  );

endinterface

// File: rtl/ex_irq_sync.sv
// ex_irq_sync: N-flop level synchroniser for the external IRQ,
// cleared to 0 by the asynchronous active-low reset.
module ex_irq_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/ex_epu.sv
// ex_epu: exception processing unit driving PSR save/restore, EPC, ELSA.
// Define NCPU_EPU_PERF_CNT_EN to add the epu_exc_cnt trap counter.
module ex_epu
  import ex_epu_pkg::*;
#(
  parameter int CONFIG_DW       = 64,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ex_epu_if.slave              pipe,
  input  logic                 irq_async,
  input  logic                 msr_psr_ire,
  input  logic [CONFIG_DW-1:0] msr_evect,
  input  logic [CONFIG_DW-1:0] msr_epc,
  output logic                 msr_psr_save,
  output logic                 msr_psr_restore,
  output logic [CONFIG_DW-1:0] msr_epc_nxt,
  output logic                 msr_epc_we,
  output logic [CONFIG_DW-1:0] msr_elsa_nxt,
  output logic                 msr_elsa_we
`ifdef NCPU_EPU_PERF_CNT_EN
  ,
  output logic [31:0]          epu_exc_cnt
`endif
);

  logic             irq_sync;
  logic             accept;
  logic             irq_take;
  logic             reexec;
  logic [EXC_W-1:0] exc_oh;
  epu_ev_t          ev;

  epu_state_t state_q, state_d;

  logic save_q, save_d;
  logic restore_q, restore_d;
  logic epc_we_q, epc_we_d;
  logic elsa_we_q, elsa_we_d;

  logic [CONFIG_DW-1:0] epc_nxt_q, epc_nxt_d;
  logic [CONFIG_DW-1:0] elsa_nxt_q, elsa_nxt_d;
  logic [CONFIG_DW-1:0] redir_pc_q, redir_pc_d;
  logic [CONFIG_DW-1:0] off_x;

  ex_irq_sync #(
    .N (IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d_i (irq_async),
    .q_o (irq_sync)
  );

  assign accept = pipe.cmt_valid & pipe.cmt_ready;

  // Lowest set bit wins: bit order matches the fault priority.
  assign exc_oh = pipe.cmt_exc & (-pipe.cmt_exc);

  assign irq_take = irq_sync & msr_psr_ire
                  & ~(|pipe.cmt_exc);

  always_comb begin
    ev = EV_NONE;
    unique case (1'b1)
      exc_oh[EXC_EIPF]:     ev = EV_IPF;
      exc_oh[EXC_EINSN]:    ev = EV_INSN;
      exc_oh[EXC_ESYSCALL]: ev = EV_SYS;
      exc_oh[EXC_EDPF]:     ev = EV_DPF;
      exc_oh[EXC_ERET]:     ev = EV_RET;
      irq_take:             ev = EV_IRQ;
      default:              ev = EV_NONE;
    endcase
  end

  assign reexec = (ev == EV_IPF)
               || (ev == EV_INSN)
               || (ev == EV_DPF);

  assign off_x = {{(CONFIG_DW-VOFF_W){1'b0}},
                  vec_off(ev)};

  always_comb begin
    state_d    = state_q;
    save_d     = 1'b0;
    restore_d  = 1'b0;
    epc_we_d   = 1'b0;
    elsa_we_d  = 1'b0;
    epc_nxt_d  = epc_nxt_q;
    elsa_nxt_d = elsa_nxt_q;
    redir_pc_d = redir_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && (ev != EV_NONE)) begin
          state_d = ST_DRAIN;
          if (ev == EV_RET) begin
            restore_d  = 1'b1;
            redir_pc_d = msr_epc;
          end else begin
            save_d     = 1'b1;
            epc_we_d   = 1'b1;
            epc_nxt_d  = reexec ? pipe.cmt_pc
                                : pipe.cmt_npc;
            elsa_we_d  = (ev == EV_DPF);
            elsa_nxt_d = pipe.cmt_lsa;
            redir_pc_d = msr_evect + off_x;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe.flush_ack) begin
          state_d = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (pipe.redir_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      save_q     <= 1'b0;
      restore_q  <= 1'b0;
      epc_we_q   <= 1'b0;
      elsa_we_q  <= 1'b0;
      epc_nxt_q  <= '0;
      elsa_nxt_q <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      save_q     <= save_d;
      restore_q  <= restore_d;
      epc_we_q   <= epc_we_d;
      elsa_we_q  <= elsa_we_d;
      epc_nxt_q  <= epc_nxt_d;
      elsa_nxt_q <= elsa_nxt_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign pipe.cmt_ready   = (state_q == ST_IDLE);
  assign pipe.flush_req   = (state_q == ST_DRAIN);
  assign pipe.redir_valid = (state_q == ST_REDIR);
  assign pipe.redir_pc    = redir_pc_q;

  assign msr_psr_save    = save_q;
  assign msr_psr_restore = restore_q;
  assign msr_epc_we      = epc_we_q;
  assign msr_epc_nxt     = epc_nxt_q;
  assign msr_elsa_we     = elsa_we_q;
  assign msr_elsa_nxt    = elsa_nxt_q;

`ifdef NCPU_EPU_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = save_q ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign epu_exc_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ex_epu.sv
// tb_ex_epu: directed vector table, hand sequences and randomized
// commits checked against a priority-rule reference model.
module tb_ex_epu;
  import ex_epu_pkg::*;

  localparam int DW = 64;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_epu_if #(.DW(DW)) bus ();

  logic          irq_async;
  logic          msr_psr_ire;
  logic [DW-1:0] msr_evect;
  logic [DW-1:0] msr_epc;
  logic          msr_psr_save;
  logic          msr_psr_restore;
  logic [DW-1:0] msr_epc_nxt;
  logic          msr_epc_we;
  logic [DW-1:0] msr_elsa_nxt;
  logic          msr_elsa_we;
`ifdef NCPU_EPU_PERF_CNT_EN
  logic [31:0]   epu_exc_cnt;
`endif

  ex_epu #(
    .CONFIG_DW       (DW),
    .IRQ_SYNC_STAGES (NS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pipe            (bus),
    .irq_async       (irq_async),
    .msr_psr_ire     (msr_psr_ire),
    .msr_evect       (msr_evect),
    .msr_epc         (msr_epc),
    .msr_psr_save    (msr_psr_save),
    .msr_psr_restore (msr_psr_restore),
    .msr_epc_nxt     (msr_epc_nxt),
    .msr_epc_we      (msr_epc_we),
    .msr_elsa_nxt    (msr_elsa_nxt),
    .msr_elsa_we     (msr_elsa_we)
`ifdef NCPU_EPU_PERF_CNT_EN
    ,
    .epu_exc_cnt     (epu_exc_cnt)
`endif
  );

  typedef struct {
    string       nm;
    logic [4:0]  exc;
    bit          irq;
    bit          ire;
    logic [63:0] pc;
    logic [63:0] npc;
    logic [63:0] lsa;
    logic [63:0] evect;
    logic [63:0] epc;
    int          ack_dly;
    int          rdy_dly;
    bit          save;
    bit          restore;
    bit          elsa_we;
    logic [63:0] epc_nxt;
    logic [63:0] elsa;
    logic [63:0] redir;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  vec_t vq[$];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string nm, input logic [4:0] exc,
    input bit irq, input bit ire,
    input logic [63:0] pc, input logic [63:0] npc,
    input logic [63:0] lsa, input logic [63:0] evect,
    input logic [63:0] epc, input int ack_dly,
    input int rdy_dly, input bit save,
    input bit restore, input bit elsa_we,
    input logic [63:0] epc_nxt,
    input logic [63:0] elsa,
    input logic [63:0] redir);
    vec_t v;
    v.nm = nm; v.exc = exc; v.irq = irq; v.ire = ire;
    v.pc = pc; v.npc = npc; v.lsa = lsa;
    v.evect = evect; v.epc = epc;
    v.ack_dly = ack_dly; v.rdy_dly = rdy_dly;
    v.save = save; v.restore = restore;
    v.elsa_we = elsa_we; v.epc_nxt = epc_nxt;
    v.elsa = elsa; v.redir = redir;
    return v;
  endfunction

  // Reference: walk the priority list, first set cause wins.
  function automatic vec_t model(input vec_t v);
    int prio[5];
    logic [63:0] offs[5];
    int win;
    vec_t r;
    prio = '{0, 1, 2, 3, 4};
    offs = '{64'h18, 64'h08, 64'h10, 64'h20, 64'h0};
    r = v;
    r.save = 0; r.restore = 0; r.elsa_we = 0;
    r.epc_nxt = 0; r.elsa = 0; r.redir = 0;
    win = -1;
    for (int i = 0; i < 5; i++)
      if (win < 0 && v.exc[prio[i]]) win = prio[i];
    if (win == 4) begin
      r.restore = 1;
      r.redir = v.epc;
    end else if (win >= 0) begin
      r.save = 1;
      r.epc_nxt = (win == 2) ? v.npc : v.pc;
      r.elsa_we = (win == 3);
      r.elsa = v.lsa;
      r.redir = v.evect + offs[win];
    end else if (v.irq && v.ire) begin
      r.save = 1;
      r.epc_nxt = v.npc;
      r.redir = v.evect + 64'h28;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    bus.cmt_valid   = 0;
    bus.cmt_exc     = 0;
    bus.cmt_pc      = 0;
    bus.cmt_npc     = 0;
    bus.cmt_lsa     = 0;
    bus.flush_ack   = 0;
    bus.redir_ready = 0;
    irq_async       = 0;
    msr_psr_ire     = 0;
    msr_evect       = 0;
    msr_epc         = 0;
  endtask

  // Entered at the pulse cycle (one cycle after accept).
  task automatic finish_seq(input vec_t v);
    int  cyc;
    bit  bad_rdy;
    bit  bad_pc;
    bit  pulse_again;
    logic [63:0] first_pc;
    check({v.nm, "_save"}, msr_psr_save, v.save);
    check({v.nm, "_restore"}, msr_psr_restore, v.restore);
    check({v.nm, "_epc_we"}, msr_epc_we, v.save);
    check({v.nm, "_elsa_we"}, msr_elsa_we, v.elsa_we);
    if (v.save)
      check({v.nm, "_epc_nxt"}, msr_epc_nxt, v.epc_nxt);
    if (v.elsa_we)
      check({v.nm, "_elsa_nxt"}, msr_elsa_nxt, v.elsa);
    cyc = 0; bad_rdy = 0; pulse_again = 0;
    while (bus.flush_req && cyc < 64) begin
      if (bus.cmt_ready) bad_rdy = 1;
      bus.flush_ack = (cyc >= v.ack_dly);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1)
        pulse_again = msr_psr_save | msr_psr_restore
                    | msr_epc_we | msr_elsa_we;
    end
    bus.flush_ack = 0;
    check({v.nm, "_drain_cycles"}, cyc, v.ack_dly + 1);
    check({v.nm, "_pulse_once"}, pulse_again, 0);
    cyc = 0; bad_pc = 0;
    first_pc = bus.redir_pc;
    while (bus.redir_valid && cyc < 64) begin
      if (bus.cmt_ready) bad_rdy = 1;
      if (bus.redir_pc !== v.redir) bad_pc = 1;
      bus.redir_ready = (cyc >= v.rdy_dly);
      @(posedge clk); #1;
      cyc++;
    end
    bus.redir_ready = 0;
    check({v.nm, "_redir_cycles"}, cyc, v.rdy_dly + 1);
    check({v.nm, "_redir_pc"}, first_pc, v.redir);
    check({v.nm, "_redir_stable"}, bad_pc, 0);
    check({v.nm, "_busy_not_ready"}, bad_rdy, 0);
    check({v.nm, "_back_idle"}, bus.cmt_ready, 1);
    if (v.save) exp_cnt++;
`ifdef NCPU_EPU_PERF_CNT_EN
    check({v.nm, "_exc_cnt"}, epu_exc_cnt, exp_cnt);
`endif
  endtask

  // Entered at posedge+1 with the EPU idle; IRQ already settled.
  task automatic run_commit(input vec_t v);
    check({v.nm, "_ready"}, bus.cmt_ready, 1);
    bus.cmt_valid = 1;
    bus.cmt_exc   = v.exc;
    bus.cmt_pc    = v.pc;
    bus.cmt_npc   = v.npc;
    bus.cmt_lsa   = v.lsa;
    msr_psr_ire   = v.ire;
    msr_evect     = v.evect;
    msr_epc       = v.epc;
    @(posedge clk); #1;
    bus.cmt_valid = 0;
    bus.cmt_exc   = 5'($urandom);
    msr_evect     = {$urandom, $urandom};
    msr_epc       = {$urandom, $urandom};
    msr_psr_ire   = 1'($urandom);
    if (v.save || v.restore) begin
      finish_seq(v);
    end else begin
      check({v.nm, "_no_save"}, msr_psr_save, 0);
      check({v.nm, "_no_restore"}, msr_psr_restore, 0);
      check({v.nm, "_no_flush"}, bus.flush_req, 0);
      check({v.nm, "_still_ready"}, bus.cmt_ready, 1);
    end
  endtask

  task automatic settle_irq(input bit lvl);
    irq_async = lvl;
    repeat (NS + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit   bad;
    idle_inputs();
    #12;
    check("rst_ready", bus.cmt_ready, 1);
    check("rst_save", msr_psr_save, 0);
    check("rst_restore", msr_psr_restore, 0);
    check("rst_epc_we", msr_epc_we, 0);
    check("rst_elsa_we", msr_elsa_we, 0);
    check("rst_flush", bus.flush_req, 0);
    check("rst_redir_valid", bus.redir_valid, 0);
    check("rst_epc_nxt", msr_epc_nxt, 0);
    check("rst_elsa_nxt", msr_elsa_nxt, 0);
    check("rst_redir_pc", bus.redir_pc, 0);
`ifdef NCPU_EPU_PERF_CNT_EN
    check("rst_exc_cnt", epu_exc_cnt, 0);
`endif
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;

    vq.push_back(mk("einsn", 5'b00010, 0, 0,
      64'h1000, 64'h1004, 64'h0, 64'h8000, 64'h0, 2, 0,
      1, 0, 0, 64'h1000, 64'h0, 64'h8008));
    vq.push_back(mk("edpf", 5'b01000, 0, 0,
      64'h2000, 64'h2004, 64'hDEAD0, 64'h8000, 64'h0, 0, 1,
      1, 0, 1, 64'h2000, 64'hDEAD0, 64'h8020));
    vq.push_back(mk("ret_sys", 5'b10100, 0, 0,
      64'h3000, 64'h3004, 64'h0, 64'h8000, 64'h7777, 1, 2,
      1, 0, 0, 64'h3004, 64'h0, 64'h8010));
    vq.push_back(mk("irq", 5'b00000, 1, 1,
      64'h4000, 64'h4004, 64'h0, 64'h8000, 64'h0, 0, 0,
      1, 0, 0, 64'h4004, 64'h0, 64'h8028));
    vq.push_back(mk("irq_masked", 5'b00000, 1, 0,
      64'h4000, 64'h4004, 64'h0, 64'h8000, 64'h0, 0, 0,
      0, 0, 0, 64'h0, 64'h0, 64'h0));
    vq.push_back(mk("ret", 5'b10000, 0, 0,
      64'h5100, 64'h5104, 64'h0, 64'h8000, 64'h5000, 0, 3,
      0, 1, 0, 64'h0, 64'h0, 64'h5000));
    vq.push_back(mk("eipf_all", 5'b11111, 1, 1,
      64'h6000, 64'h6004, 64'h55, 64'h9000, 64'h0, 1, 1,
      1, 0, 0, 64'h6000, 64'h0, 64'h9018));
    vq.push_back(mk("ret_dpf", 5'b11000, 0, 0,
      64'h6100, 64'h6104, 64'hBEEF8, 64'h9000, 64'h1, 0, 0,
      1, 0, 1, 64'h6100, 64'hBEEF8, 64'h9020));
    vq.push_back(mk("wrap_insn", 5'b00010, 0, 0,
      64'h7000, 64'h7004, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0,
      64'h0, 0, 0, 1, 0, 0, 64'h7000, 64'h0,
      64'hFFFF_FFFF_FFFF_FFF8));
    vq.push_back(mk("wrap_sys", 5'b00100, 0, 0,
      64'h7100, 64'h7104, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0,
      64'h0, 3, 0, 1, 0, 0, 64'h7104, 64'h0, 64'h0));
    vq.push_back(mk("plain", 5'b00000, 0, 1,
      64'h7200, 64'h7204, 64'h0, 64'h8000, 64'h0, 0, 0,
      0, 0, 0, 64'h0, 64'h0, 64'h0));

    foreach (vq[i]) begin
      settle_irq(vq[i].irq);
      run_commit(vq[i]);
    end

    // Back-to-back commits while the IRQ crosses the synchroniser.
    settle_irq(0);
    bus.cmt_valid = 1;
    bus.cmt_exc   = 0;
    bus.cmt_pc    = 64'h4100;
    bus.cmt_npc   = 64'h4104;
    msr_psr_ire   = 1;
    msr_evect     = 64'hA000;
    irq_async     = 1;
    bad = 0;
    for (int k = 0; k < NS; k++) begin
      @(posedge clk); #1;
      if (msr_psr_save || !bus.cmt_ready) bad = 1;
    end
    check("irq_not_early", bad, 0);
    @(posedge clk); #1;
    bus.cmt_valid = 0;
    irq_async = 0;
    finish_seq(mk("irq_sync", 5'b0, 1, 1,
      64'h4100, 64'h4104, 64'h0, 64'hA000, 64'h0, 0, 0,
      1, 0, 0, 64'h4104, 64'h0, 64'hA028));

    // IRQ pulse that drops before the commit is not remembered.
    settle_irq(1);
    settle_irq(0);
    run_commit(mk("irq_gone", 5'b0, 0, 1,
      64'h4200, 64'h4204, 64'h0, 64'hA000, 64'h0, 0, 0,
      0, 0, 0, 64'h0, 64'h0, 64'h0));

    // RET beats a pending IRQ; the IRQ is taken at the next commit.
    settle_irq(1);
    run_commit(mk("ret_over_irq", 5'b10000, 1, 1,
      64'h4300, 64'h4304, 64'h0, 64'hA000, 64'h5500, 1, 0,
      0, 1, 0, 64'h0, 64'h0, 64'h5500));
    run_commit(mk("irq_after_ret", 5'b0, 1, 1,
      64'h4400, 64'h4404, 64'h0, 64'hA000, 64'h0, 0, 1,
      1, 0, 0, 64'h4404, 64'h0, 64'hA028));
    settle_irq(0);

    // Reset while in the pulse/drain cycle.
    bus.cmt_valid = 1;
    bus.cmt_exc   = 5'b00010;
    bus.cmt_pc    = 64'h1230;
    msr_evect     = 64'h8000;
    @(posedge clk); #1;
    bus.cmt_valid = 0;
    check("rstmid_pre_save", msr_psr_save, 1);
    rst = 0;
    #1;
    exp_cnt = 0;
    check("rstmid_save", msr_psr_save, 0);
    check("rstmid_epc_we", msr_epc_we, 0);
    check("rstmid_flush", bus.flush_req, 0);
    check("rstmid_redir_valid", bus.redir_valid, 0);
    check("rstmid_epc_nxt", msr_epc_nxt, 0);
    check("rstmid_redir_pc", bus.redir_pc, 0);
    @(posedge clk); #1;
    rst = 1;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (msr_psr_save || msr_psr_restore || bus.flush_req
          || bus.redir_valid || !bus.cmt_ready) bad = 1;
    end
    check("rstmid_quiet", bad, 0);
`ifdef NCPU_EPU_PERF_CNT_EN
    check("rstmid_exc_cnt", epu_exc_cnt, 0);
`endif

    // Randomized commits against the reference model.
    for (int n = 0; n < 40; n++) begin
      v.nm      = $sformatf("rnd%0d", n);
      v.exc     = ($urandom_range(0, 2) == 0) ? 5'b0
                                             : 5'($urandom);
      v.irq     = 1'($urandom);
      v.ire     = 1'($urandom);
      v.pc      = {$urandom, $urandom};
      v.npc     = v.pc + 64'd4;
      v.lsa     = {$urandom, $urandom};
      v.evect   = ($urandom_range(0, 3) == 0)
                ? 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31))
                : {$urandom, $urandom};
      v.epc     = {$urandom, $urandom};
      v.ack_dly = $urandom_range(0, 3);
      v.rdy_dly = $urandom_range(0, 3);
      v = model(v);
      settle_irq(v.irq);
      run_commit(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
